// File: rtl/key_pulse_gen.sv
// Pushbutton conditioner: synchronizes and debounces a raw key, then emits single-cycle
// pulses on each accepted press and, optionally, periodic repeat pulses while held.
module key_pulse_gen #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned KEY_ACTIVE_LOW  = 1,
    parameter int unsigned COUNT_W         = 16
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               key_in,
    input  logic               repeat_en,
    output logic               pulse,
    output logic               key_level,
    output logic [COUNT_W-1:0] press_count
);

    localparam int unsigned CNT_W = 32;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // Raw key level that corresponds to "not pressed".
    localparam logic RELEASED_LVL = (KEY_ACTIVE_LOW != 0);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        REPEAT,
        DEB_RELEASE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   cnt_inc_c;
    logic               pulse_d;
    logic               level_d;
    logic [COUNT_W-1:0] count_d;
    logic               fire_c;
    logic               pressed_c;

    logic [SYNC_STAGES-1:0] sync_q;

    // Metastability synchronizer; reset loads the released level so no phantom press appears.
    always_ff @(posedge clock) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RELEASED_LVL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_in};
        end
    end

    assign pressed_c = sync_q[SYNC_STAGES-1] ^ RELEASED_LVL;
    assign cnt_inc_c = cnt_q + CNT_W'(1);

    // State, timer and registered outputs.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pulse       <= 1'b0;
            key_level   <= 1'b0;
            press_count <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse       <= pulse_d;
            key_level   <= level_d;
            press_count <= count_d;
        end
    end

    // Next-state logic; release always wins over a timer expiry in the same cycle.
    // A timer expiry that would follow a pulse directly is held off one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = key_level;
        fire_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pressed_c) begin
                    state_d = DEB_PRESS;
                end
            end

            DEB_PRESS: begin
                if (!pressed_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    fire_c  = 1'b1;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end

            HELD: begin
                if (!pressed_c) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = '0;
                end else if (repeat_en && (cnt_q == DLY_LAST) && !pulse) begin
                    state_d = REPEAT;
                    cnt_d   = '0;
                    fire_c  = 1'b1;
                end else if (cnt_q != DLY_LAST) begin
                    cnt_d = cnt_inc_c;
                end
            end

            REPEAT: begin
                if (!pressed_c) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = '0;
                end else if (!repeat_en) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == PER_LAST) begin
                    if (!pulse) begin
                        cnt_d  = '0;
                        fire_c = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end

            DEB_RELEASE: begin
                if (pressed_c) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase

        pulse_d = fire_c;
        count_d = fire_c ? (press_count + COUNT_W'(1)) : press_count;
    end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen with short timers; expected pulse edges are hand-derived.
module tb_key_pulse_gen;

    logic       clock;
    logic       rst;
    logic       key_in;
    logic       repeat_en;
    logic       pulse;
    logic       key_level;
    logic [3:0] press_count;

    int         vectors;
    int         miscompares;
    logic [3:0] exp_cnt;

    key_pulse_gen #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .KEY_ACTIVE_LOW (1),
        .COUNT_W        (4)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .key_in     (key_in),
        .repeat_en  (repeat_en),
        .pulse      (pulse),
        .key_level  (key_level),
        .press_count(press_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic release_and_settle();
        key_in    = 1'b1;
        repeat_en = 1'b0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        key_in    = 1'b1;
        repeat_en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        exp_cnt = 4'd0;
        vectors++;
        if (pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pulse got=%0b exp=0", pulse);
        end
        vectors++;
        if (key_level !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_level got=%0b exp=0", key_level);
        end
        vectors++;
        if (press_count !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_count got=%0d exp=0", press_count);
        end
    endtask

    task automatic test_clean_press();
        logic exp_p;
        logic exp_l;
        key_in = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            exp_p = (e == 7);
            exp_l = (e >= 7);
            if (exp_p) exp_cnt = exp_cnt + 4'd1;
            vectors++;
            if (pulse !== exp_p) begin
                miscompares++;
                $display("FAIL clean_pulse e=%0d got=%0b exp=%0b", e, pulse, exp_p);
            end
            vectors++;
            if (key_level !== exp_l) begin
                miscompares++;
                $display("FAIL clean_level e=%0d got=%0b exp=%0b", e, key_level, exp_l);
            end
        end
        vectors++;
        if (press_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL clean_count got=%0d exp=%0d", press_count, exp_cnt);
        end
        key_in = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp_l = (e < 7);
            vectors++;
            if (key_level !== exp_l || pulse !== 1'b0) begin
                miscompares++;
                $display("FAIL clean_release e=%0d level=%0b exp=%0b pulse=%0b exp=0",
                         e, key_level, exp_l, pulse);
            end
        end
    endtask

    task automatic test_bounce();
        int pulses;
        pulses = 0;
        for (int e = 0; e < 27; e++) begin
            key_in = (e < 12) ? logic'((e / 2) % 2) : 1'b1;
            tick();
            if (pulse === 1'b1) pulses++;
            vectors++;
            if (key_level !== 1'b0) begin
                miscompares++;
                $display("FAIL bounce_level e=%0d got=%0b exp=0", e, key_level);
            end
        end
        // Four pressed samples fall one short of acceptance.
        for (int e = 1; e <= 16; e++) begin
            key_in = (e <= 4) ? 1'b0 : 1'b1;
            tick();
            if (pulse === 1'b1) pulses++;
            vectors++;
            if (key_level !== 1'b0) begin
                miscompares++;
                $display("FAIL short_level e=%0d got=%0b exp=0", e, key_level);
            end
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL bounce_pulses got=%0d exp=0", pulses);
        end
        vectors++;
        if (press_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL bounce_count got=%0d exp=%0d", press_count, exp_cnt);
        end
    endtask

    task automatic test_auto_repeat();
        logic exp_p;
        logic exp_l;
        repeat_en = 1'b1;
        for (int e = 1; e <= 50; e++) begin
            key_in = (e <= 35) ? 1'b0 : 1'b1;
            tick();
            exp_p = (e == 7) || (e >= 17 && e <= 35 && ((e - 17) % 3) == 0);
            exp_l = (e >= 7 && e <= 41);
            if (exp_p) exp_cnt = exp_cnt + 4'd1;
            vectors++;
            if (pulse !== exp_p) begin
                miscompares++;
                $display("FAIL repeat_pulse e=%0d got=%0b exp=%0b", e, pulse, exp_p);
            end
            vectors++;
            if (key_level !== exp_l) begin
                miscompares++;
                $display("FAIL repeat_level e=%0d got=%0b exp=%0b", e, key_level, exp_l);
            end
        end
        vectors++;
        if (press_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL repeat_count got=%0d exp=%0d", press_count, exp_cnt);
        end
        release_and_settle();
    endtask

    task automatic test_release_glitch();
        logic exp_p;
        logic exp_l;
        repeat_en = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            key_in = (e <= 26 && e != 11 && e != 12) ? 1'b0 : 1'b1;
            tick();
            exp_p = (e == 7) || (e == 25) || (e == 28);
            exp_l = (e >= 7 && e <= 32);
            if (exp_p) exp_cnt = exp_cnt + 4'd1;
            vectors++;
            if (pulse !== exp_p) begin
                miscompares++;
                $display("FAIL glitch_pulse e=%0d got=%0b exp=%0b", e, pulse, exp_p);
            end
            vectors++;
            if (key_level !== exp_l) begin
                miscompares++;
                $display("FAIL glitch_level e=%0d got=%0b exp=%0b", e, key_level, exp_l);
            end
        end
        vectors++;
        if (press_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL glitch_count got=%0d exp=%0d", press_count, exp_cnt);
        end
        release_and_settle();
    endtask

    task automatic test_saturate();
        logic exp_p;
        key_in = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            repeat_en = (e >= 31 && e <= 34);
            tick();
            exp_p = (e == 7) || (e == 31) || (e == 34);
            if (exp_p) exp_cnt = exp_cnt + 4'd1;
            vectors++;
            if (pulse !== exp_p) begin
                miscompares++;
                $display("FAIL sat_pulse e=%0d got=%0b exp=%0b", e, pulse, exp_p);
            end
        end
        vectors++;
        if (press_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL sat_count got=%0d exp=%0d", press_count, exp_cnt);
        end
        release_and_settle();
        vectors++;
        if (key_level !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_release_level got=%0b exp=0", key_level);
        end
    endtask

    task automatic test_reset_mid();
        logic exp_p;
        key_in    = 1'b0;
        repeat_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        for (int phase = 0; phase < 2; phase++) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            exp_cnt = 4'd0;
            vectors++;
            if (pulse !== 1'b0 || key_level !== 1'b0 || press_count !== 4'd0) begin
                miscompares++;
                $display("FAIL midreset_%0d pulse=%0b level=%0b count=%0d exp=0/0/0",
                         phase, pulse, key_level, press_count);
            end
            for (int e = 1; e <= 18; e++) begin
                tick();
                exp_p = (e == 7) || (e == 17);
                if (exp_p) exp_cnt = exp_cnt + 4'd1;
                vectors++;
                if (pulse !== exp_p) begin
                    miscompares++;
                    $display("FAIL midreset_pulse p=%0d e=%0d got=%0b exp=%0b",
                             phase, e, pulse, exp_p);
                end
            end
        end
        vectors++;
        if (press_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL midreset_count got=%0d exp=%0d", press_count, exp_cnt);
        end
        release_and_settle();
    endtask

    task automatic test_wrap();
        int pulses;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 4'd0;
        for (int p = 1; p <= 17; p++) begin
            pulses = 0;
            key_in = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (pulse === 1'b1) pulses++;
            end
            key_in = 1'b1;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (pulse === 1'b1) pulses++;
            end
            exp_cnt = exp_cnt + 4'd1;
            vectors++;
            if (pulses != 1) begin
                miscompares++;
                $display("FAIL wrap_pulses pair=%0d got=%0d exp=1", p, pulses);
            end
            if (p >= 15) begin
                vectors++;
                if (press_count !== exp_cnt) begin
                    miscompares++;
                    $display("FAIL wrap_count pair=%0d got=%0d exp=%0d", p, press_count, exp_cnt);
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_cnt     = 4'd0;
        rst         = 1'b1;
        key_in      = 1'b1;
        repeat_en   = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_release_glitch();
        test_saturate();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
